// File: rtl/img_regs_pkg.sv
// Shared definitions for the multi-channel image-path control/status
// register slave: register indices, channel stride, AXI response codes and
// the write/read handshake state encodings.
package img_regs_pkg;

  localparam logic [3:0]  REG_CTRL      = 4'd0;
  localparam logic [3:0]  REG_I2C_CTRL  = 4'd1;
  localparam logic [3:0]  REG_I2C_DATA  = 4'd2;
  localparam logic [3:0]  REG_LVDS_STAT = 4'd3;
  localparam logic [3:0]  REG_IRQ_STAT  = 4'd4;
  localparam logic [3:0]  REG_IRQ_EN    = 4'd5;

  // Address distance between consecutive channel register banks.
  localparam logic [31:0] CH_STRIDE     = 32'h0000_0040;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;

  // Read value for unmapped registers and nonexistent channels.
  localparam logic [31:0] RD_UNMAPPED   = 32'hFFFF_FFFF;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } wr_state_t;
  typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rd_state_t;

endpackage

// File: rtl/img_regs_sync2.sv
// Two-flop synchronizer of parametrised width for quasi-static status
// levels arriving from another clock domain.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both stages
//   din  - asynchronous input bits
//   dout - synchronized output bits (two destination clocks of latency)
module img_regs_sync2
  import img_regs_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_p0;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  assign dout = sync_p1;

endmodule

// File: rtl/img_ctrl_regs_mc.sv
// AXI4-Lite control/status register slave for CH_NUM image sensor channels.
// Each channel owns a 0x40-byte bank (addr[9:6] = channel, addr[5:2] = reg):
// CTRL (im_rst/im_oe), I2C_CTRL (trigger, bit count, done), I2C_DATA,
// LVDS_STAT and, when IMG_REGS_IRQ_EN is defined, IRQ_STAT (W1C) / IRQ_EN.
// Without IMG_REGS_IRQ_EN registers 4/5 read as unmapped and irq is 0.
// Ports:
//   s_axi_*         - AXI4-Lite slave, single clock s_axi_aclk
//   rst             - asynchronous active-high reset
//   ch_im_rst/oe    - per-channel image-path reset / output enable
//   ch_i2c_*        - per-channel I2C engine trigger, bit count, data, done
//   ch_mmcm_locked,
//   ch_align_err    - per-channel LVDS status, asynchronous to the clock
//   irq             - level interrupt
module img_ctrl_regs_mc
  import img_regs_pkg::*;
#(
  parameter int TCQ    = 100,
  parameter int CH_NUM = 2
) (
  input  logic                   s_axi_aclk,
  input  logic                   rst,
  input  logic [31:0]            s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [31:0]            s_axi_wdata,
  input  logic [3:0]             s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [31:0]            s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [31:0]            s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [CH_NUM-1:0]      ch_im_rst,
  output logic [CH_NUM-1:0]      ch_im_oe,
  output logic [CH_NUM-1:0]      ch_i2c_trg,
  output logic [4*CH_NUM-1:0]    ch_i2c_bit_num,
  output logic [11*CH_NUM-1:0]   ch_i2c_din,
  input  logic [10*CH_NUM-1:0]   ch_i2c_dout,
  input  logic [CH_NUM-1:0]      ch_i2c_done,
  input  logic [CH_NUM-1:0]      ch_mmcm_locked,
  input  logic [CH_NUM-1:0]      ch_align_err,
  output logic                   irq
);

  if (CH_NUM < 1 || CH_NUM > 8 || TCQ < 0) begin : g_param_check
    $error("img_ctrl_regs_mc: CH_NUM must be 1..8 and TCQ non-negative");
  end

  localparam logic [4:0] CH_LIM = 5'(CH_NUM);

  wr_state_t w_state;
  rd_state_t r_state;

  logic [3:0] w_ch, w_reg, r_ch, r_reg;
  logic       w_ch_ok, r_ch_ok, w_fire, r_fire;

  logic [CH_NUM-1:0]      wr_sel;
  logic [CH_NUM-1:0]      im_rst_r, im_oe_r, trg_r;
  logic [3:0]             bit_num_r [CH_NUM];
  logic [10:0]            din_r     [CH_NUM];
  logic [CH_NUM-1:0][1:0] lvds_s;   // {align_err, locked}, synchronized

  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

`ifdef IMG_REGS_IRQ_EN
  logic [2:0]        irq_stat_r [CH_NUM];
  logic [2:0]        irq_en_r   [CH_NUM];
  logic [2:0]        irq_ev     [CH_NUM];
  logic [2:0]        irq_clr    [CH_NUM];
  logic [CH_NUM-1:0] done_q, lock_q, align_q;
  logic              irq_any;
`endif

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[31:10], s_axi_awaddr[1:0],
                         s_axi_araddr[31:10], s_axi_araddr[1:0],
                         s_axi_wdata[31:12], s_axi_wstrb[3:2]};

  assign w_ch    = s_axi_awaddr[9:6];
  assign w_reg   = s_axi_awaddr[5:2];
  assign r_ch    = s_axi_araddr[9:6];
  assign r_reg   = s_axi_araddr[5:2];
  assign w_ch_ok = ({1'b0, w_ch} < CH_LIM);
  assign r_ch_ok = ({1'b0, r_ch} < CH_LIM);

  // Address and data are only taken together; both readies stay low in reset.
  assign w_fire        = (w_state == W_IDLE) && s_axi_awvalid && s_axi_wvalid && !rst;
  assign s_axi_awready = w_fire;
  assign s_axi_wready  = w_fire;
  assign s_axi_arready = (r_state == R_IDLE) && !rst;
  assign r_fire        = s_axi_arready && s_axi_arvalid;

  always_comb begin
    wr_sel = '0;
    for (int n = 0; n < CH_NUM; n++)
      wr_sel[n] = w_fire && w_ch_ok && (w_ch == 4'(n));
  end

  // Write channel: accept edge -> response held until bready.
  always_ff @(posedge s_axi_aclk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: if (w_fire) begin
          w_state      <= W_RESP;
          s_axi_bvalid <= 1'b1;
          s_axi_bresp  <= w_ch_ok ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP: if (s_axi_bready) begin
          w_state      <= W_IDLE;
          s_axi_bvalid <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register file; trg_r is a single-cycle pulse following the accept edge.
  always_ff @(posedge s_axi_aclk or posedge rst) begin
    if (rst) begin
      im_rst_r <= '1;
      im_oe_r  <= '0;
      trg_r    <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        bit_num_r[n] <= '0;
        din_r[n]     <= '0;
      end
    end else begin
      trg_r <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        if (wr_sel[n]) begin
          case (w_reg)
            REG_CTRL: if (s_axi_wstrb[0]) begin
              im_rst_r[n] <= s_axi_wdata[0];
              im_oe_r[n]  <= s_axi_wdata[3];
            end
            REG_I2C_CTRL: begin
              trg_r[n] <= s_axi_wstrb[0] & s_axi_wdata[0];
              if (s_axi_wstrb[1]) bit_num_r[n] <= s_axi_wdata[11:8];
            end
            REG_I2C_DATA: begin
              if (s_axi_wstrb[0]) din_r[n][7:0]  <= s_axi_wdata[7:0];
              if (s_axi_wstrb[1]) din_r[n][10:8] <= s_axi_wdata[10:8];
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    img_regs_sync2 #(.WIDTH(2)) u_sync (
      .clk  (s_axi_aclk),
      .rst  (rst),
      .din  ({ch_align_err[n], ch_mmcm_locked[n]}),
      .dout (lvds_s[n])
    );
    assign ch_i2c_bit_num[4*n +: 4] = bit_num_r[n];
    assign ch_i2c_din[11*n +: 11]   = din_r[n];
  end

  assign ch_im_rst  = im_rst_r;
  assign ch_im_oe   = im_oe_r;
  assign ch_i2c_trg = trg_r;

  always_comb begin
    rd_word = RD_UNMAPPED;
    rd_resp = RESP_SLVERR;
    if (r_ch_ok) begin
      rd_resp = RESP_OKAY;
      for (int n = 0; n < CH_NUM; n++) begin
        if (r_ch == 4'(n)) begin
          case (r_reg)
            REG_CTRL:      rd_word = {28'd0, im_oe_r[n], 2'b00, im_rst_r[n]};
            REG_I2C_CTRL:  rd_word = {15'd0, ch_i2c_done[n], 4'd0, bit_num_r[n], 8'd0};
            REG_I2C_DATA:  rd_word = {22'd0, ch_i2c_dout[10*n +: 10]};
            REG_LVDS_STAT: rd_word = {30'd0, lvds_s[n]};
`ifdef IMG_REGS_IRQ_EN
            REG_IRQ_STAT:  rd_word = {29'd0, irq_stat_r[n]};
            REG_IRQ_EN:    rd_word = {29'd0, irq_en_r[n]};
`endif
            default:       rd_word = RD_UNMAPPED;
          endcase
        end
      end
    end
  end

  // Read channel: data captured from pre-write state on the accept edge.
  always_ff @(posedge s_axi_aclk or posedge rst) begin
    if (rst) begin
      r_state      <= R_IDLE;
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (r_fire) begin
          r_state      <= R_DATA;
          s_axi_rvalid <= 1'b1;
          s_axi_rdata  <= rd_word;
          s_axi_rresp  <= rd_resp;
        end
        R_DATA: if (s_axi_rready) begin
          r_state      <= R_IDLE;
          s_axi_rvalid <= 1'b0;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef IMG_REGS_IRQ_EN
  always_comb begin
    irq_any = 1'b0;
    for (int n = 0; n < CH_NUM; n++) begin
      // bit2 locked falling, bit1 align_err rising, bit0 done rising
      irq_ev[n]  = {lock_q[n] & ~lvds_s[n][0],
                    lvds_s[n][1] & ~align_q[n],
                    ch_i2c_done[n] & ~done_q[n]};
      irq_clr[n] = (wr_sel[n] && (w_reg == REG_IRQ_STAT) && s_axi_wstrb[0])
                   ? s_axi_wdata[2:0] : 3'b000;
      irq_any    = irq_any | (|(irq_stat_r[n] & irq_en_r[n]));
    end
  end

  // A new event wins over a coincident W1C clear of the same bit.
  always_ff @(posedge s_axi_aclk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      lock_q  <= '0;
      align_q <= '0;
      irq     <= 1'b0;
      for (int n = 0; n < CH_NUM; n++) begin
        irq_stat_r[n] <= '0;
        irq_en_r[n]   <= '0;
      end
    end else begin
      done_q <= ch_i2c_done;
      irq    <= irq_any;
      for (int n = 0; n < CH_NUM; n++) begin
        lock_q[n]     <= lvds_s[n][0];
        align_q[n]    <= lvds_s[n][1];
        irq_stat_r[n] <= (irq_stat_r[n] & ~irq_clr[n]) | irq_ev[n];
        if (wr_sel[n] && (w_reg == REG_IRQ_EN) && s_axi_wstrb[0])
          irq_en_r[n] <= s_axi_wdata[2:0];
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/img_ctrl_regs_mc.md
# img_ctrl_regs_mc

Multi-channel AXI4-Lite control/status register slave for the image path, supporting `CH_NUM` sensor channels. Each channel drives image-path reset and output enable, feeds its I2C transaction engine, and reports LVDS/I2C status. The block uses a compliant AXI-Lite handshake, byte strobes, and per-channel sticky interrupt status. It sits between the PS AXI-Lite interconnect and the per-channel sensor I2C and LVDS bridge instances.

## Interface
Parameters:
- `TCQ`, 100: clock-to-Q delay, in ps, used in simulation.
- `CH_NUM`, 2: number of sensor channels, from 1 to 8.

Ports (`ch_*` vectors are flattened; channel n occupies slice n):
- `s_axi_aclk`  in  1  single clock for everything.
- `rst`  in  1  asynchronous, active-high reset.
- `s_axi_awaddr`  in  32; `s_axi_awvalid`  in  1; `s_axi_awready`  out  1.
- `s_axi_wdata`  in  32; `s_axi_wstrb`  in  4; `s_axi_wvalid`  in  1; `s_axi_wready`  out  1.
- `s_axi_bresp`  out  2; `s_axi_bvalid`  out  1; `s_axi_bready`  in  1.
- `s_axi_araddr`  in  32; `s_axi_arvalid`  in  1; `s_axi_arready`  out  1.
- `s_axi_rdata`  out  32; `s_axi_rresp`  out  2; `s_axi_rvalid`  out  1; `s_axi_rready`  in  1.
- `ch_im_rst`  out  CH_NUM  image-path reset per channel.
- `ch_im_oe`  out  CH_NUM  image output enable per channel.
- `ch_i2c_trg`  out  CH_NUM  one-cycle I2C start pulse.
- `ch_i2c_bit_num`  out  4*CH_NUM  I2C transfer bit count.
- `ch_i2c_din`  out  11*CH_NUM  I2C transmit data.
- `ch_i2c_dout`  in  10*CH_NUM  I2C receive data; synchronous to the clock.
- `ch_i2c_done`  in  CH_NUM  I2C done level; synchronous to the clock.
- `ch_mmcm_locked`, `ch_align_err`  in  CH_NUM each  asynchronous to the clock (pixel/MMCM domain).
- `irq`  out  1  level interrupt.

## Operation
Address decode:
- `addr[9:6]` selects the channel.
- `addr[5:2]` selects the register.
- Channel index ≥ CH_NUM → SLVERR (`resp` = 2'b10); writes are ignored and reads return 0xFFFF_FFFF.

Per-channel registers:
- 0 CTRL, RW.
  - Bit 0: im_rst, reset value 1.
  - Bit 3: im_oe, reset value 0.
- 1 I2C_CTRL.
  - Bit 0: W trg pulse.
  - Bits [11:8]: RW bit_num.
  - Bit 16: RO done.
- 2 I2C_DATA.
  - Write: [10:0] din.
  - Read: [9:0] dout.
- 3 LVDS_STAT, RO.
  - Bit 0: locked.
  - Bit 1: align_err.
  - Both bits are synchronized.
- 4 IRQ_STAT, W1C.
  - Bit 0: done rising edge.
  - Bit 1: align_err rising edge.
  - Bit 2: locked falling edge.
- 5 IRQ_EN, RW [2:0], reset value 0.
- Other indices → OKAY; reads return 0xFFFF_FFFF and writes are ignored.

Byte strobes:
- Byte k of a register is written only when `wstrb[k]` = 1.
- trg fires only when `wstrb[0]` = 1 and `wdata[0]` = 1.

Interrupt and synchronization:
- `irq` = OR over channels of |(IRQ_STAT & IRQ_EN), registered.
- `ch_mmcm_locked` and `ch_align_err` pass through 2-flop synchronizers before use.

## Timing
Write FSM, states W_IDLE and W_RESP:
- `awready` = `wready` = W_IDLE & `awvalid` & `wvalid`, combinational. Address and data are accepted together.
- The register updates on the accept edge; the FSM then enters W_RESP with `bvalid` = 1.
- `bvalid` holds until `bready`, then the FSM returns to W_IDLE. `awready`/`wready` are 0 while in W_RESP.
- Back-to-back writes: one accept every 2 cycles when `bready` is held high.

Read FSM, states R_IDLE and R_DATA:
- `arready` = 1 in R_IDLE.
- On `arvalid`, `rdata`/`rresp` are registered from the current state and the FSM enters R_DATA; `rvalid` = 1 the next cycle.
- `rdata` stays stable until `rready`, then the FSM returns to R_IDLE.

Pulses and edges:
- `ch_i2c_trg` is high exactly one cycle, the cycle after the accept edge.
- Edge detectors compare synchronized current vs previous values.
- An event is visible in IRQ_STAT 1 cycle after the synchronized edge, or 3 cycles for async inputs.
- `irq` follows IRQ_STAT/IRQ_EN with 1 cycle latency.

Simultaneous events:
- W1C clear and a new event on the same bit in the same cycle → the bit stays set.
- Read and write may complete in the same cycle. The read returns the pre-write value.

Reset values (any time, including mid-transaction):
- Both FSMs go to idle.
- `awready`/`wready` = 0, `arready` = 0 during reset.
- `bvalid` = 0, `rvalid` = 0, `bresp`/`rresp` = 0.
- `rdata` = 0, `irq` = 0.
- `ch_im_rst` = all 1s, `ch_im_oe` = 0, `ch_i2c_trg` = 0.
- `bit_num` = 0, `din` = 0.
- Synchronizers and IRQ_STAT = 0.

## Configuration
`IMG_REGS_IRQ_EN`:
- Defined: IRQ_STAT, IRQ_EN, the edge detectors and `irq` are present.
- Undefined:
  - Registers 4 and 5 behave as unmapped (read 0xFFFF_FFFF, writes ignored).
  - `irq` is tied to 0.
  - The edge-detect logic is removed.
  - The LVDS synchronizers remain.

## Structure
Package `img_regs_pkg` holds:
- Register index constants: REG_CTRL=0, REG_I2C_CTRL=1, REG_I2C_DATA=2, REG_LVDS_STAT=3, REG_IRQ_STAT=4, REG_IRQ_EN=5.
- CH_STRIDE=0x40.
- Response codes: RESP_OKAY, RESP_SLVERR.
- Write/read FSM state encodings.

Sub-module `img_regs_sync2` is a parametrised-width 2-flop synchronizer with ASYNC_REG flops. It is instantiated once per channel, covering locked and align_err.

## Test plan
- Reset, then read CTRL on channel 0 and channel 1 → 0x0000_0001; `ch_im_rst` = all 1s; `irq` = 0.
- Write CTRL on channel 1 with `wdata` 0x8 and `wstrb` 0x1 → `ch_im_oe[1]` = 1 and `ch_im_rst[1]` = 0; repeat with `wstrb` 0x0 → no change; `bresp` = 00.
- Write I2C_CTRL on channel 0 with 0x0000_0701 → `ch_i2c_trg[0]` high exactly 1 cycle and `bit_num` = 7. Raise `ch_i2c_done[0]` → read I2C_CTRL returns bit 16 = 1.
- With IRQ_EN on channel 1 = 0x2, toggle `ch_align_err[1]` 0→1 → `irq` = 1 within 5 cycles. Write 0x2 to IRQ_STAT → `irq` = 0. A clear coincident with a new edge leaves the bit set.
- Write and read channel 8 with CH_NUM=2 → `resp` = 2'b10 and `rdata` = 0xFFFF_FFFF. Holding `bready`/`rready` low keeps `bvalid`/`rvalid` and `rdata` stable.
- Assert `rst` while `bvalid` = 1 → `bvalid` = 0 immediately, and the next write completes normally.
